// File: rtl/drrip_duel_ctrl.sv
// Set-dueling controller for DRRIP: classifies missing sets as leaders or followers,
// trains PSEL from leader misses and holds a registered insertion decision per fill.
module drrip_duel_ctrl #(
  parameter int unsigned INDEX_WIDTH       = 5,
  parameter int unsigned LEADER_BITS       = 2,
  parameter int unsigned PSEL_WIDTH        = 10,
  parameter int unsigned M                 = 2,
  parameter int unsigned BRRIP_COUNTER_LEN = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    miss_valid,
  input  logic [INDEX_WIDTH-1:0]  miss_index,
  output logic                    miss_ready,
  input  logic                    fill_done,
  output logic                    sel_valid,
  output logic                    sel,
  output logic [M-1:0]            insert_rrpv,
  output logic [PSEL_WIDTH-1:0]   psel
);

  localparam logic [M-1:0]          RRPV_DISTANT = M'((2**M) - 1);
  localparam logic [M-1:0]          RRPV_LONG    = M'((2**M) - 2);
  localparam logic [PSEL_WIDTH-1:0] PSEL_MAX     = '1;
  localparam logic [PSEL_WIDTH-1:0] PSEL_INIT    = PSEL_WIDTH'((2**(PSEL_WIDTH-1)) - 1);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e                       state_q, state_d;
  logic                         sel_d;
  logic [M-1:0]                 rrpv_d;
  logic [PSEL_WIDTH-1:0]        psel_d;
  logic [BRRIP_COUNTER_LEN-1:0] thr_q, thr_d;
  logic [LEADER_BITS-1:0]       idx_hi, idx_lo;
  logic                         is_srrip, is_brrip;

  // Leader classification compares the top K index bits against the bottom K.
  assign idx_hi   = LEADER_BITS'(miss_index >> (INDEX_WIDTH - LEADER_BITS));
  assign idx_lo   = LEADER_BITS'(miss_index);
  assign is_srrip = (idx_hi == idx_lo);
  assign is_brrip = (idx_hi == ~idx_lo);

  assign miss_ready = (state_q == IDLE);
  assign sel_valid  = (state_q == HOLD);

  always_comb begin
    state_d = state_q;
    sel_d   = sel;
    rrpv_d  = insert_rrpv;
    psel_d  = psel;
    thr_d   = thr_q;
    case (state_q)
      IDLE: begin
        if (miss_valid) begin
          state_d = HOLD;
          if (is_srrip)      sel_d = 1'b0;
          else if (is_brrip) sel_d = 1'b1;
          else               sel_d = psel[PSEL_WIDTH-1];
          // BRRIP inserts LONG only when the throttle sits at zero.
          if (sel_d) begin
            rrpv_d = (thr_q == '0) ? RRPV_LONG : RRPV_DISTANT;
            thr_d  = thr_q + BRRIP_COUNTER_LEN'(1);
          end else begin
            rrpv_d = RRPV_LONG;
          end
          if (is_srrip && (psel != PSEL_MAX)) psel_d = psel + PSEL_WIDTH'(1);
          if (is_brrip && (psel != '0))       psel_d = psel - PSEL_WIDTH'(1);
        end
      end
      HOLD: begin
        if (fill_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sel         <= 1'b0;
      insert_rrpv <= '0;
      psel        <= PSEL_INIT;
      thr_q       <= '0;
    end else begin
      state_q     <= state_d;
      sel         <= sel_d;
      insert_rrpv <= rrpv_d;
      psel        <= psel_d;
      thr_q       <= thr_d;
    end
  end

endmodule

// File: tb/tb_drrip_duel_ctrl.sv
// Directed bench for drrip_duel_ctrl: leader/follower decisions, throttle wrap,
// PSEL saturation, held-miss behaviour and reset priority.
module tb_drrip_duel_ctrl;

  localparam int unsigned INDEX_WIDTH = 5;
  localparam int unsigned PSEL_WIDTH  = 10;
  localparam int unsigned M           = 2;

  logic                   clk;
  logic                   rst;
  logic                   miss_valid;
  logic [INDEX_WIDTH-1:0] miss_index;
  logic                   miss_ready;
  logic                   fill_done;
  logic                   sel_valid;
  logic                   sel;
  logic [M-1:0]           insert_rrpv;
  logic [PSEL_WIDTH-1:0]  psel;

  int n_checks = 0;
  int n_errors = 0;

  drrip_duel_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .miss_valid  (miss_valid),
    .miss_index  (miss_index),
    .miss_ready  (miss_ready),
    .fill_done   (fill_done),
    .sel_valid   (sel_valid),
    .sel         (sel),
    .insert_rrpv (insert_rrpv),
    .psel        (psel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are observed on the falling edge.
  task automatic do_reset();
    rst = 1'b1; miss_valid = 1'b0; fill_done = 1'b0; miss_index = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_accept(input int idx);
    miss_valid = 1'b1;
    miss_index = INDEX_WIDTH'(idx);
    @(negedge clk);
    miss_valid = 1'b0;
  endtask

  task automatic do_fill();
    fill_done = 1'b1;
    @(negedge clk);
    fill_done = 1'b0;
  endtask

  initial begin
    rst = 1'b1; miss_valid = 1'b0; fill_done = 1'b0; miss_index = '0;
    @(negedge clk);
    do_reset();

    // Reset state
    check("rst_ready", int'(miss_ready), 1);
    check("rst_valid", int'(sel_valid), 0);
    check("rst_sel", int'(sel), 0);
    check("rst_rrpv", int'(insert_rrpv), 0);
    check("rst_psel", int'(psel), 511);

    // fill_done in IDLE is ignored
    do_fill();
    check("idle_fill_ready", int'(miss_ready), 1);
    check("idle_fill_valid", int'(sel_valid), 0);

    // Follower at reset PSEL chooses SRRIP
    do_accept(1);
    check("fol_valid", int'(sel_valid), 1);
    check("fol_ready", int'(miss_ready), 0);
    check("fol_sel", int'(sel), 0);
    check("fol_rrpv", int'(insert_rrpv), 2);
    check("fol_psel", int'(psel), 511);
    do_fill();
    check("fol_done_ready", int'(miss_ready), 1);
    check("fol_done_valid", int'(sel_valid), 0);

    // SRRIP leader flips PSEL MSB, followers then use BRRIP
    do_reset();
    do_accept(0);
    check("sl_psel", int'(psel), 512);
    check("sl_sel", int'(sel), 0);
    check("sl_rrpv", int'(insert_rrpv), 2);
    do_fill();
    do_accept(1);
    check("fb1_sel", int'(sel), 1);
    check("fb1_rrpv", int'(insert_rrpv), 2);
    check("fb1_psel", int'(psel), 512);
    do_fill();
    do_accept(1);
    check("fb2_sel", int'(sel), 1);
    check("fb2_rrpv", int'(insert_rrpv), 3);
    do_fill();

    // Throttle wrap over 33 BRRIP-leader accepts
    do_reset();
    for (int i = 0; i < 33; i++) begin
      do_accept(3);
      check($sformatf("thr_rrpv_%0d", i), int'(insert_rrpv), (i == 0 || i == 32) ? 2 : 3);
      check($sformatf("thr_sel_%0d", i), int'(sel), 1);
      do_fill();
    end
    check("thr_psel", int'(psel), 511 - 33);
    for (int i = 0; i < 500; i++) begin
      do_accept(3);
      do_fill();
    end
    check("floor_psel", int'(psel), 0);
    do_accept(3);
    check("floor_hold", int'(psel), 0);
    do_fill();

    // PSEL saturation at the top
    do_reset();
    for (int i = 0; i < 600; i++) begin
      do_accept(4);
      do_fill();
    end
    check("sat_psel", int'(psel), 1023);
    do_accept(3);
    check("sat_dec", int'(psel), 1022);
    do_fill();

    // Held miss_valid: one update, stable HOLD outputs, index changes ignored
    do_reset();
    miss_valid = 1'b1;
    miss_index = INDEX_WIDTH'(0);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("hold_psel_%0d", i), int'(psel), 512);
      check($sformatf("hold_sel_%0d", i), int'(sel), 0);
      check($sformatf("hold_rrpv_%0d", i), int'(insert_rrpv), 2);
      check($sformatf("hold_valid_%0d", i), int'(sel_valid), 1);
      miss_index = INDEX_WIDTH'(3);
      @(negedge clk);
    end
    miss_index = INDEX_WIDTH'(0);
    fill_done  = 1'b1;
    @(negedge clk);
    fill_done = 1'b0;
    check("reacc_idle", int'(miss_ready), 1);
    check("reacc_psel0", int'(psel), 512);
    @(negedge clk);
    miss_valid = 1'b0;
    check("reacc_valid", int'(sel_valid), 1);
    check("reacc_psel1", int'(psel), 513);
    do_fill();

    // Reset during HOLD overrides fill_done and a pending miss
    do_accept(3);
    do_fill();
    do_accept(0);
    rst = 1'b1; fill_done = 1'b1; miss_valid = 1'b1; miss_index = INDEX_WIDTH'(0);
    @(negedge clk);
    rst = 1'b0; fill_done = 1'b0; miss_valid = 1'b0;
    check("hrst_valid", int'(sel_valid), 0);
    check("hrst_ready", int'(miss_ready), 1);
    check("hrst_psel", int'(psel), 511);
    check("hrst_sel", int'(sel), 0);
    check("hrst_rrpv", int'(insert_rrpv), 0);
    do_accept(3);
    check("hrst_thr_rrpv", int'(insert_rrpv), 2);
    check("hrst_thr_psel", int'(psel), 510);
    do_fill();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/drrip_duel_ctrl.md
# drrip_duel_ctrl

Set-dueling controller for the DRRIP replacement datapath. On each cache miss it classifies the missing set as an SRRIP leader, a BRRIP leader or a follower, and trains a saturating policy-select counter (PSEL) from leader-set misses. It returns a registered policy decision and insertion RRPV that the replacement unit holds for the duration of the fill. It sits between the cache miss/fill FSM and the per-set RRIP table update logic.

## Interface
- INDEX_WIDTH, 5: set-index width (DEPTH = 2**INDEX_WIDTH sets).
- LEADER_BITS, 2: K, the bits compared for leader selection; 2*K <= INDEX_WIDTH is required.
- PSEL_WIDTH, 10: policy-select counter width.
- M, 2: RRPV width. DISTANT = 2**M-1, LONG = 2**M-2.
- BRRIP_COUNTER_LEN, 5: BRRIP throttle counter width (LONG inserted 1 in 2**5 BRRIP fills).

- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- miss_valid  in  1  cache reports a miss for miss_index; held high while the miss is pending.
- miss_index  in  INDEX_WIDTH  set index of the miss.
- miss_ready  out  1  controller can accept a miss (state IDLE).
- fill_done  in  1  single-cycle pulse: fill/victim insertion for the held miss has completed.
- sel_valid  out  1  decision valid (state HOLD).
- sel  out  1  0 = SRRIP insertion, 1 = BRRIP insertion.
- insert_rrpv  out  M  RRPV to write into the filled way.
- psel  out  PSEL_WIDTH  current PSEL value, for perf counters and debug.

## Operation
- Leader classification: hi = miss_index[INDEX_WIDTH-1 -: K], lo = miss_index[K-1:0].
  - hi == lo: SRRIP leader.
  - hi == ~lo: BRRIP leader.
  - Otherwise: follower.
  - Indices 0 and 4 are SRRIP leaders, 3 is a BRRIP leader, and 1 is a follower (defaults).
- FSM has two states.
  - IDLE: miss_ready=1, sel_valid=0.
  - HOLD: miss_ready=0, sel_valid=1.
- Accept: in IDLE, miss_valid=1 moves the FSM to HOLD at the next edge and registers sel and insert_rrpv.
  - miss_index is sampled only in the accept cycle.
- Decision at accept:
  - SRRIP leader: sel=0.
  - BRRIP leader: sel=1.
  - Follower: sel = psel[PSEL_WIDTH-1].
- Insertion value:
  - sel=0: insert_rrpv = LONG.
  - sel=1: insert_rrpv = LONG if the throttle counter == 0 before increment, else DISTANT.
  - The throttle counter increments (wrapping modulo 2**BRRIP_COUNTER_LEN) only on accepts with sel=1.
- PSEL training happens on accept only.
  - SRRIP leader miss: psel+1, saturating at 2**PSEL_WIDTH-1.
  - BRRIP leader miss: psel-1, saturating at 0.
  - Follower miss: no change.
- Exactly one PSEL update and at most one throttle increment occur per accepted miss, regardless of how many cycles miss_valid stays high.
- HOLD: sel and insert_rrpv are stable. miss_valid is ignored.
  - fill_done=1 returns the FSM to IDLE at the next edge.
- fill_done in IDLE is ignored.

## Timing
- Reset values: FSM=IDLE, miss_ready=1, sel_valid=0, sel=0, insert_rrpv=0, psel=2**(PSEL_WIDTH-1)-1 (511 by default, MSB=0, so followers start SRRIP), throttle=0.
- Latency: accept in cycle t gives sel_valid, sel, insert_rrpv and the updated psel visible in cycle t+1.
- The follower decision uses psel as it was before the same-cycle update.
- fill_done in cycle t+1, the first HOLD cycle, is legal: IDLE and miss_ready=1 at t+2. A new miss can be accepted at t+2 at the earliest.
- Back-to-back misses therefore accept at most every 2 cycles.
- miss_valid held high across fill_done: the FSM re-accepts in the next IDLE cycle and counts it as a new miss. The cache deasserts miss_valid after its fill completes.
- rst asserted in any state forces all reset values at the next edge; it overrides a same-cycle accept or fill_done.
- All outputs are registered except miss_ready and sel_valid, which decode directly from the FSM state register.

## Test plan
- After reset, accept index 1 (follower) -> next cycle sel_valid=1, sel=0, insert_rrpv=2, psel=511. Then fill_done -> miss_ready=1 on the following cycle.
- From reset, accept index 0 (SRRIP leader) -> psel=512, sel=0. fill_done, then accept index 1 -> sel=1, insert_rrpv=2 (throttle was 0). Another cycle, index 1 -> sel=1, insert_rrpv=3.
- Throttle wrap: 33 consecutive BRRIP-leader (index 3) accepts -> insert_rrpv=2 on the 1st and 33rd, 3 on all others. psel floors at 0 and stays 0.
- Saturation: 600 accepts at index 4 -> psel reaches 1023 and holds. One accept at index 3 -> psel=1022.
- Hold miss_valid=1 with index 0 for 10 cycles before fill_done -> psel increments exactly once, and sel/insert_rrpv stay stable throughout HOLD.
- Assert rst while in HOLD with fill_done=1 -> next cycle IDLE, sel_valid=0, psel=511, throttle=0.
